// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore sequencing controller for the multi-cycle MIPS datapath
//
// Steps each instruction through fetch, decode, execute, memory and write-back,
// driving every datapath mux select and write enable. Stalls in FETCH, MEMRD and
// MEMWR until memReady is high.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, forces IDLE (all outputs 0)
//   opcode[5:0]  instruction[31:26] from the instruction register
//   zero         ALU zero flag (branch resolution is done in the datapath)
//   memReady     memory completes the access this cycle
//   pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite,
//   memToReg, regDst, regWrite, aluSrcA       datapath controls
//   aluSrcB[1:0] 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
//   aluOp[1:0]   00 add, 01 sub, 10 funct field, 11 immediate op from opcode
//   pcSrc[1:0]   00 ALU result, 01 ALUOut, 10 jump target
//   instrDone    one-cycle pulse on the final cycle of each instruction
//   illegal      one-cycle pulse in DECODE for an unsupported opcode

module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic       instrDone,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    IEXEC,
    IWB,
    BRANCH,
    JUMP
  } state_t;

  state_t state;
  state_t state_next;

  // The branch decision is taken by the datapath (pcWriteCond & zero), so the
  // flag is deliberately not consumed here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    irWrite     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSrc       = 2'b00;
    instrDone   = 1'b0;
    illegal     = 1'b0;

    case (state)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        // IR load and PC+4 only on the cycle the instruction word arrives.
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady) begin
          state_next = DECODE;
        end
      end

      DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_LH, OP_LHU, OP_SW: state_next = MEMADR;
          OP_RTYPE:                    state_next = EXEC;
          OP_ADDI, OP_ANDI, OP_ORI:    state_next = IEXEC;
          OP_BEQ:                      state_next = BRANCH;
          OP_J:                        state_next = JUMP;
          default: begin
            illegal    = 1'b1;
            instrDone  = 1'b1;
            state_next = FETCH;
          end
        endcase
      end

      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        // Only loads and SW reach here; the IR still holds the same opcode.
        state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
      end

      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) begin
          state_next = MEMWB;
        end
      end

      MEMWB: begin
        regWrite   = 1'b1;
        memToReg   = 1'b1;
        instrDone  = 1'b1;
        state_next = FETCH;
      end

      MEMWR: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = memReady;
        if (memReady) begin
          state_next = FETCH;
        end
      end

      EXEC: begin
        aluSrcA    = 1'b1;
        aluOp      = 2'b10;
        state_next = ALUWB;
      end

      ALUWB: begin
        regWrite   = 1'b1;
        regDst     = 1'b1;
        instrDone  = 1'b1;
        state_next = FETCH;
      end

      IEXEC: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        aluOp      = 2'b11;
        state_next = IWB;
      end

      IWB: begin
        regWrite   = 1'b1;
        instrDone  = 1'b1;
        state_next = FETCH;
      end

      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSrc       = 2'b01;
        instrDone   = 1'b1;
        state_next  = FETCH;
      end

      JUMP: begin
        pcWrite    = 1'b1;
        pcSrc      = 2'b10;
        instrDone  = 1'b1;
        state_next = FETCH;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm

module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite;
  logic       memToReg, regDst, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic       instrDone, illegal;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .memReady    (memReady),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .iorD        (iorD),
    .irWrite     (irWrite),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memToReg    (memToReg),
    .regDst      (regDst),
    .regWrite    (regWrite),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .pcSrc       (pcSrc),
    .instrDone   (instrDone),
    .illegal     (illegal)
  );

  // Packed view of all outputs, same field order as exp_word.
  logic [17:0] dut_word;
  assign dut_word = {pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite,
                     memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc,
                     instrDone, illegal};

  typedef enum int {
    B_FETCH, B_DECODE, B_DECODE_ILL, B_MEMADR, B_MEMRD, B_MEMWB, B_MEMWR,
    B_EXEC, B_ALUWB, B_IEXEC, B_IWB, B_BRANCH, B_JUMP
  } b_state_t;

  typedef struct {
    b_state_t s;
    logic     mr;
  } cyc_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    int         fwait;
    int         mwait;
    int         exp_cycles;
  } vec_t;

  cyc_t        seq[$];
  logic [17:0] sb[$];
  vec_t        vecs[14];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [17:0] exp_word(b_state_t s, logic mr);
    logic pw = 0, pwc = 0, iord = 0, irw = 0, mrd = 0, mwr = 0;
    logic m2r = 0, rdst = 0, rw = 0, asa = 0, done = 0, ill = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    case (s)
      B_FETCH:      begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      B_DECODE:     begin asb = 2'b11; end
      B_DECODE_ILL: begin asb = 2'b11; ill = 1; done = 1; end
      B_MEMADR:     begin asa = 1; asb = 2'b10; end
      B_MEMRD:      begin mrd = 1; iord = 1; end
      B_MEMWB:      begin rw = 1; m2r = 1; done = 1; end
      B_MEMWR:      begin mwr = 1; iord = 1; done = mr; end
      B_EXEC:       begin asa = 1; aop = 2'b10; end
      B_ALUWB:      begin rw = 1; rdst = 1; done = 1; end
      B_IEXEC:      begin asa = 1; asb = 2'b10; aop = 2'b11; end
      B_IWB:        begin rw = 1; done = 1; end
      B_BRANCH:     begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      B_JUMP:       begin pw = 1; psrc = 2'b10; done = 1; end
      default:      ;
    endcase
    return {pw, pwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input int cyc, input logic [17:0] got,
                       input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  task automatic push_wait(input b_state_t s, input int waits);
    for (int i = 0; i < waits; i++) seq.push_back('{s, 1'b0});
    seq.push_back('{s, 1'b1});
  endtask

  // Builds the expected per-cycle state walk of one instruction.
  task automatic build_seq(input logic [5:0] op, input int fwait, input int mwait);
    seq.delete();
    push_wait(B_FETCH, fwait);
    case (op)
      6'h23, 6'h21, 6'h25: begin
        seq.push_back('{B_DECODE, rnd_bit()});
        seq.push_back('{B_MEMADR, rnd_bit()});
        push_wait(B_MEMRD, mwait);
        seq.push_back('{B_MEMWB, rnd_bit()});
      end
      6'h2B: begin
        seq.push_back('{B_DECODE, rnd_bit()});
        seq.push_back('{B_MEMADR, rnd_bit()});
        push_wait(B_MEMWR, mwait);
      end
      6'h00: begin
        seq.push_back('{B_DECODE, rnd_bit()});
        seq.push_back('{B_EXEC, rnd_bit()});
        seq.push_back('{B_ALUWB, rnd_bit()});
      end
      6'h08, 6'h0C, 6'h0D: begin
        seq.push_back('{B_DECODE, rnd_bit()});
        seq.push_back('{B_IEXEC, rnd_bit()});
        seq.push_back('{B_IWB, rnd_bit()});
      end
      6'h04: begin
        seq.push_back('{B_DECODE, rnd_bit()});
        seq.push_back('{B_BRANCH, rnd_bit()});
      end
      6'h02: begin
        seq.push_back('{B_DECODE, rnd_bit()});
        seq.push_back('{B_JUMP, rnd_bit()});
      end
      default: seq.push_back('{B_DECODE_ILL, rnd_bit()});
    endcase
  endtask

  // Drives seq cycle by cycle; expected words go through the scoreboard queue.
  task automatic drive_seq(input string name, input logic [5:0] op, input int exp_cycles);
    int n = 0;
    int done_at = -1;
    logic [17:0] e;
    foreach (seq[i]) begin
      @(negedge clk);
      opcode   = op;
      memReady = seq[i].mr;
      zero     = rnd_bit();
      sb.push_back(exp_word(seq[i].s, seq[i].mr));
      #1;
      n++;
      e = sb.pop_front();
      check(name, n, dut_word, e);
      checks++;
      if ((pcWrite && pcWriteCond) || (memRead && memWrite)) begin
        errors++;
        $display("FAIL %s_exclusive cycle=%0d pcw=%b pcwc=%b mrd=%b mwr=%b required no overlap",
                 name, n, pcWrite, pcWriteCond, memRead, memWrite);
      end
      if (instrDone && done_at < 0) done_at = n;
    end
    if (exp_cycles > 0) begin
      checks++;
      if (done_at != exp_cycles) begin
        errors++;
        $display("FAIL %s_latency got=%0d expected=%0d", name, done_at, exp_cycles);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{"rtype",      6'h00, 0, 0, 4};
    vecs[1]  = '{"rtype_fw",   6'h00, 1, 0, 5};
    vecs[2]  = '{"lw_wait2",   6'h23, 0, 2, 7};
    vecs[3]  = '{"lh",         6'h21, 0, 0, 5};
    vecs[4]  = '{"lhu_fw2",    6'h25, 2, 1, 8};
    vecs[5]  = '{"sw",         6'h2B, 0, 0, 4};
    vecs[6]  = '{"sw_wait1",   6'h2B, 0, 1, 5};
    vecs[7]  = '{"addi",       6'h08, 0, 0, 4};
    vecs[8]  = '{"andi",       6'h0C, 0, 0, 4};
    vecs[9]  = '{"ori",        6'h0D, 0, 0, 4};
    vecs[10] = '{"beq",        6'h04, 0, 0, 3};
    vecs[11] = '{"j",          6'h02, 0, 0, 3};
    vecs[12] = '{"illegal3f",  6'h3F, 0, 0, 2};
    vecs[13] = '{"illegal01",  6'h01, 1, 0, 3};

    reset    = 1'b1;
    opcode   = 6'h00;
    zero     = 1'b0;
    memReady = 1'b1;
    @(negedge clk);
    #1;
    check("reset_hold", 0, dut_word, 18'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_after_reset", 0, dut_word, 18'h0);

    foreach (vecs[i]) begin
      build_seq(vecs[i].op, vecs[i].fwait, vecs[i].mwait);
      drive_seq(vecs[i].name, vecs[i].op, vecs[i].exp_cycles);
    end

    // Reset asserted mid-instruction while LW is stalled in MEMRD.
    seq.delete();
    seq.push_back('{B_FETCH, 1'b1});
    seq.push_back('{B_DECODE, 1'b0});
    seq.push_back('{B_MEMADR, 1'b0});
    seq.push_back('{B_MEMRD, 1'b0});
    drive_seq("lw_pre_reset", 6'h23, -1);
    reset = 1'b1;
    #1;
    check("reset_async_same_cycle", 0, dut_word, 18'h0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 0, dut_word, 18'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_after_mid_reset", 0, dut_word, 18'h0);
    build_seq(6'h00, 0, 0);
    drive_seq("rtype_after_reset", 6'h00, 4);
    build_seq(6'h3F, 0, 0);
    drive_seq("illegal_then", 6'h3F, 2);
    build_seq(6'h23, 0, 0);
    drive_seq("lw_back_to_back", 6'h23, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
